dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Parametrised data-memory access unit for the MIPS core's memory stage. It turns the stage's load/store request into a handshaked SRAM-like bus transaction (req / addr_ok / data_ok), with configurable bus width. It generates byte strobes, load extraction and extension, and address-error exceptions. It stalls the pipeline until the access completes and drains in-flight transactions killed by a pipeline flush.

## Interface
Parameters:
- DATA_W, 32: bus data width; legal values 32 or 64. LANES = DATA_W/8; OFFW = log2(LANES).
- ADDR_W, 32: bus address width; must be ≥ 32.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  M-stage instruction valid.
- opcode_i  in  6  MIPS opcode.
  - Loads: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101.
  - Stores: SB 101000, SH 101001, SW 101011.
  - Any other value is a non-memory instruction.
- addr_i  in  32  effective byte address.
- wdata_i  in  32  store data, right-aligned.
- flush_i  in  1  pipeline flush (exception/eret) for the M-stage instruction.
- stall_o  out  1  hold the pipeline.
- busy_o  out  1  a bus transaction is outstanding.
- rdata_o  out  32  extended load result.
- rdata_valid_o  out  1  one-cycle pulse, load result valid.
- adel_o  out  1  load address error.
- ades_o  out  1  store address error.
- badvaddr_o  out  32  faulting address; equals addr_i.
- req_o  out  1  bus request.
- wr_o  out  1  1 = write.
- size_o  out  2  0 = byte, 1 = half, 2 = word.
- addr_o  out  ADDR_W  byte address; zero-extended addr_i.
- wdata_o  out  DATA_W  write data, lane-replicated.
- wstrb_o  out  LANES  byte strobes.
- addr_ok_i  in  1  address accepted.
- data_ok_i  in  1  data returned / write done.
- rdata_i  in  DATA_W  bus read data.

## Operation
- Start condition: mem_op & valid_i & ~flush_i & ~adel_o & ~ades_o.
- Address errors (combinational):
  - Half-word access with addr_i[0] = 1 raises an error.
  - Word access with addr_i[1:0] ≠ 0 raises an error.
  - Loads raise adel_o; stores raise ades_o.
  - No request is issued and no stall is raised.
- Address, size and wr are captured on start.
- wdata_o: byte replicated ×LANES, half replicated ×LANES/2, or word replicated ×LANES/4.
- wstrb_o: base mask (0x1, 0x3 or 0xF) shifted left by addr[OFFW-1:0]. Loads drive wstrb_o = 0.
- Load extraction: rdata_i >> (8·addr[OFFW-1:0]), then take the low 8/16/32 bits. LB/LH sign-extend; LBU/LHU zero-extend. The result is registered on data_ok_i.
- FSM states:
  - IDLE → REQ on start.
  - REQ: req_o = 1. On addr_ok_i & data_ok_i → DONE. On addr_ok_i alone → WAIT.
  - WAIT: req_o = 0. On data_ok_i → DONE.
  - DONE: lasts one cycle, then → IDLE.
- req_o, once asserted, stays high with stable addr/size/wr/wdata/wstrb until addr_ok_i; it is never withdrawn.
- Kill flag:
  - Set by flush_i while in REQ or WAIT.
  - A killed transaction still completes its handshake. Its DONE gives rdata_valid_o = 0, and the flag clears on exit from DONE.
- stall_o:
  - Asserted for (IDLE & start), REQ, and WAIT, while not killed.
  - Also asserted while killed and a new mem_op & valid_i is present, so a new access waits for the drain.
  - Low in DONE, so the pipeline advances that cycle.
- busy_o = (state ≠ IDLE).
- data_ok_i in IDLE is ignored. data_ok_i is never expected before addr_ok_i.

## Timing
- Reset values: state IDLE, kill 0, and every registered output 0 (req_o, wr_o, size_o, addr_o, wdata_o, wstrb_o, rdata_o, rdata_valid_o). stall_o and busy_o read 0.
- rst mid-transaction forces IDLE next cycle with req_o = 0 and no rdata_valid_o.
- Start in cycle T gives req_o = 1 in T+1.
- With zero-wait addr_ok and data_ok in T+1, DONE occurs in T+2 and stall_o falls in T+2. Minimum stall is 2 cycles.
- rdata_o and rdata_valid_o are valid in the DONE cycle. rdata_o holds until the next load completes.
- Exceptions have the same-cycle response; stall_o stays 0.
- flush_i coincident with data_ok_i in WAIT: the transaction is still killed.

## Test plan
- LW at 0x1000, DATA_W = 32, addr_ok and data_ok in the first REQ cycle, rdata_i = 0x80FF_1234 → req_o for exactly 1 cycle, stall_o high for 2 cycles, rdata_o = 0x80FF1234 with a 1-cycle rdata_valid_o pulse.
- LB at 0x1003 with rdata_i = 0x80FF_1234 → rdata_o = 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x1002 → 0x000080FF.
- DATA_W = 64, SH at 0x1006, wdata_i = 0x0000_ABCD → wstrb_o = 0xC0, wdata_o = 0xABCD replicated ×4, size_o = 1, wr_o = 1.
- LW at 0x1002 → adel_o = 1 and badvaddr_o = 0x1002 in the same cycle, req_o never asserted, stall_o = 0. SH at 0x1001 → ades_o = 1.
- LW with addr_ok delayed 3 cycles and data_ok 2 cycles later, flush_i pulsed in WAIT, next LW already presented → req_o held stable for 4 cycles, no rdata_valid_o, busy_o high until data_ok. The new LW stalls during the drain and its req_o rises the cycle after the drain DONE.
- rst asserted in WAIT → next cycle state IDLE, req_o = 0, busy_o = 0. A later data_ok_i is ignored.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: M-stage load/store to a req/addr_ok/data_ok bus,
// with strobes, load extension, address errors, stall and flush drain.
// Ports: clk/rst; valid_i/opcode_i/addr_i/wdata_i/flush_i from the M stage;
// stall_o/busy_o/rdata_o/rdata_valid_o/adel_o/ades_o/badvaddr_o to the core;
// req_o/wr_o/size_o/addr_o/wdata_o/wstrb_o/addr_ok_i/data_ok_i/rdata_i bus.
module dmem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [5:0]            opcode_i,
   input  logic [31:0]           addr_i,
   input  logic [31:0]           wdata_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic [31:0]           rdata_o,
   output logic                  rdata_valid_o,
   output logic                  adel_o,
   output logic                  ades_o,
   output logic [31:0]           badvaddr_o,
   output logic                  req_o,
   output logic                  wr_o,
   output logic [1:0]            size_o,
   output logic [ADDR_W-1:0]     addr_o,
   output logic [DATA_W-1:0]     wdata_o,
   output logic [DATA_W/8-1:0]   wstrb_o,
   input  logic                  addr_ok_i,
   input  logic                  data_ok_i,
   input  logic [DATA_W-1:0]     rdata_i
);

   localparam int LANES = DATA_W / 8;
   localparam int OFFW  = $clog2(LANES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              kill_q, kill_d;
   logic              req_q, req_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [LANES-1:0]  wstrb_q, wstrb_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   logic              is_ld, is_st, is_sgn, mem_op;
   logic [1:0]        sz;
   logic              mis, start, go, complete, in_flight;
   logic [DATA_W-1:0] wdata_rep;
   logic [LANES-1:0]  base_strb;
   logic [DATA_W-1:0] rd_sh;
   logic [31:0]       rd_ext;

   always_comb begin
      is_ld  = 1'b0;
      is_st  = 1'b0;
      is_sgn = 1'b0;
      sz     = 2'd0;
      case (opcode_i)
         6'b100000: begin is_ld = 1'b1; is_sgn = 1'b1; sz = 2'd0; end
         6'b100001: begin is_ld = 1'b1; is_sgn = 1'b1; sz = 2'd1; end
         6'b100011: begin is_ld = 1'b1; sz = 2'd2; end
         6'b100100: begin is_ld = 1'b1; sz = 2'd0; end
         6'b100101: begin is_ld = 1'b1; sz = 2'd1; end
         6'b101000: begin is_st = 1'b1; sz = 2'd0; end
         6'b101001: begin is_st = 1'b1; sz = 2'd1; end
         6'b101011: begin is_st = 1'b1; sz = 2'd2; end
         default:   ;
      endcase
   end

   assign mem_op = is_ld | is_st;
   assign mis    = ((sz == 2'd1) & addr_i[0]) |
                   ((sz == 2'd2) & (addr_i[1:0] != 2'b00));
   assign adel_o = valid_i & is_ld & mis;
   assign ades_o = valid_i & is_st & mis;
   assign badvaddr_o = addr_i;
   assign start  = mem_op & valid_i & ~flush_i & ~adel_o & ~ades_o;
   assign in_flight = (state_q == S_REQ) | (state_q == S_WAIT);

   // A killed drain's DONE may hand over directly to the instruction that
   // was stalled behind it; a normal DONE still sees its own instruction.
   assign go = start & ((state_q == S_IDLE) |
                        ((state_q == S_DONE) & kill_q));

   assign complete = ((state_q == S_REQ) & addr_ok_i & data_ok_i) |
                     ((state_q == S_WAIT) & data_ok_i);

   always_comb begin
      unique case (sz)
         2'd0:    wdata_rep = {LANES{wdata_i[7:0]}};
         2'd1:    wdata_rep = {(LANES/2){wdata_i[15:0]}};
         default: wdata_rep = {(LANES/4){wdata_i}};
      endcase
      unique case (sz)
         2'd0:    base_strb = LANES'(4'h1);
         2'd1:    base_strb = LANES'(4'h3);
         default: base_strb = LANES'(4'hF);
      endcase
   end

   assign rd_sh = rdata_i >> {addr_q[OFFW-1:0], 3'b000};

   always_comb begin
      unique case (size_q)
         2'd0:    rd_ext = {{24{sgn_q & rd_sh[7]}}, rd_sh[7:0]};
         2'd1:    rd_ext = {{16{sgn_q & rd_sh[15]}}, rd_sh[15:0]};
         default: rd_ext = rd_sh[31:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (go) state_d = S_REQ;
         S_REQ: begin
            if (addr_ok_i & data_ok_i) state_d = S_DONE;
            else if (addr_ok_i)        state_d = S_WAIT;
         end
         S_WAIT: if (data_ok_i) state_d = S_DONE;
         default: state_d = go ? S_REQ : S_IDLE;
      endcase
   end

   always_comb begin
      kill_d = kill_q;
      if (in_flight & flush_i)  kill_d = 1'b1;
      if (state_q == S_DONE)    kill_d = 1'b0;

      // flush_i in the completing cycle still kills the result
      rvalid_d = complete & ~wr_q & ~kill_q & ~flush_i;
      rdata_d  = rvalid_d ? rd_ext : rdata_q;

      req_d   = (state_d == S_REQ);
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (go) begin
         wr_d    = is_st;
         size_d  = sz;
         sgn_d   = is_sgn;
         addr_d  = ADDR_W'(addr_i);
         wdata_d = wdata_rep;
         wstrb_d = is_st ? (base_strb << addr_i[OFFW-1:0]) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         kill_q   <= 1'b0;
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         sgn_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         kill_q   <= kill_d;
         req_q    <= req_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         sgn_q    <= sgn_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign stall_o = ((state_q == S_IDLE) & start) |
                    (in_flight & ~kill_q) |
                    (kill_q & mem_op & valid_i);
   assign busy_o        = (state_q != S_IDLE);
   assign req_o         = req_q;
   assign wr_o          = wr_q;
   assign size_o        = size_q;
   assign addr_o        = addr_q;
   assign wdata_o       = wdata_q;
   assign wstrb_o       = wstrb_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rvalid_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: 32- and 64-bit instances driven in lockstep,
// checked against an arithmetic model of strobes, replication and loads.
module tb_dmem_access_unit;

   localparam logic [5:0] LB  = 6'b100000;
   localparam logic [5:0] LH  = 6'b100001;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] LBU = 6'b100100;
   localparam logic [5:0] LHU = 6'b100101;
   localparam logic [5:0] SB  = 6'b101000;
   localparam logic [5:0] SH  = 6'b101001;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] ADDI = 6'b001000;

   logic clk, rst, valid_i, flush_i, addr_ok_i, data_ok_i;
   logic [5:0]  opcode_i;
   logic [31:0] addr_i, wdata_i;
   logic [31:0] rdata32_i;
   logic [63:0] rdata64_i;

   logic        stall_a, busy_a, rvalid_a, adel_a, ades_a, req_a, wr_a;
   logic [31:0] rdata_a, bad_a, addr_a, wdata_a;
   logic [1:0]  size_a;
   logic [3:0]  wstrb_a;

   logic        stall_b, busy_b, rvalid_b, adel_b, ades_b, req_b, wr_b;
   logic [31:0] rdata_b, bad_b, addr_b;
   logic [63:0] wdata_b;
   logic [1:0]  size_b;
   logic [7:0]  wstrb_b;

   int ncmp = 0;
   int nerr = 0;
   logic [31:0] exp_rd32, exp_rd64;

   dmem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut_a (
      .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .stall_o(stall_a), .busy_o(busy_a), .rdata_o(rdata_a),
      .rdata_valid_o(rvalid_a), .adel_o(adel_a), .ades_o(ades_a),
      .badvaddr_o(bad_a), .req_o(req_a), .wr_o(wr_a), .size_o(size_a),
      .addr_o(addr_a), .wdata_o(wdata_a), .wstrb_o(wstrb_a),
      .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata32_i)
   );

   dmem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut_b (
      .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .stall_o(stall_b), .busy_o(busy_b), .rdata_o(rdata_b),
      .rdata_valid_o(rvalid_b), .adel_o(adel_b), .ades_o(ades_b),
      .badvaddr_o(bad_b), .req_o(req_b), .wr_o(wr_b), .size_o(size_b),
      .addr_o(addr_b), .wdata_o(wdata_b), .wstrb_o(wstrb_b),
      .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata64_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nbytes(input logic [5:0] op);
      case (op)
         LB, LBU, SB: return 1;
         LH, LHU, SH: return 2;
         LW, SW:      return 4;
         default:     return 0;
      endcase
   endfunction

   function automatic bit is_ld(input logic [5:0] op);
      return (op[5:3] == 3'b100) && (nbytes(op) > 0);
   endfunction

   function automatic bit is_st(input logic [5:0] op);
      return (op[5:3] == 3'b101) && (nbytes(op) > 0);
   endfunction

   function automatic logic [1:0] exp_size(input logic [5:0] op);
      int nb = nbytes(op);
      return (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [31:0] exp_ld(input int lanes,
      input logic [63:0] bus, input logic [31:0] a, input logic [5:0] op);
      int nb = nbytes(op);
      int off = int'(a % lanes);
      logic [63:0] v, m;
      v = bus >> (8 * off);
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if ((op == LB || op == LH) && v[8*nb-1]) v = v | ~m;
      return v[31:0];
   endfunction

   function automatic logic [63:0] exp_strb(input int lanes,
      input logic [31:0] a, input logic [5:0] op);
      int nb = nbytes(op);
      if (!is_st(op)) return 64'd0;
      return ((64'd1 << nb) - 64'd1) << (a % lanes);
   endfunction

   function automatic logic [63:0] exp_wd(input int lanes,
      input logic [31:0] wd, input logic [5:0] op);
      int nb = nbytes(op);
      logic [63:0] r, m;
      r = 64'd0;
      m = (64'd1 << (8 * nb)) - 64'd1;
      for (int i = 0; i < lanes / nb; i++)
         r = r | (({32'd0, wd} & m) << (i * 8 * nb));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_req(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] wd);
      chk("req_a", req_a, 1);
      chk("req_b", req_b, 1);
      chk("wr_a", wr_a, is_st(op));
      chk("wr_b", wr_b, is_st(op));
      chk("size_a", size_a, exp_size(op));
      chk("size_b", size_b, exp_size(op));
      chk("addr_a", addr_a, a);
      chk("addr_b", addr_b, a);
      chk("wstrb_a", wstrb_a, exp_strb(4, a, op));
      chk("wstrb_b", wstrb_b, exp_strb(8, a, op));
      if (is_st(op)) begin
         chk("wdata_a", wdata_a, exp_wd(4, wd, op));
         chk("wdata_b", wdata_b, exp_wd(8, wd, op));
      end
      chk("stall_req", stall_a, 1);
      chk("busy_req", busy_b, 1);
   endtask

   // Entered at the first REQ cycle; returns in the IDLE cycle after DONE.
   task automatic finish_acc(input logic [5:0] op, input logic [31:0] a,
      input logic [31:0] wd, input int ad, input int dd,
      input logic [31:0] r32, input logic [63:0] r64);
      bit ld;
      ld = is_ld(op);
      for (int i = 0; i < ad; i++) begin
         #1 chk_req(op, a, wd);
         step;
      end
      addr_ok_i = 1'b1;
      data_ok_i = (dd == 0);
      rdata32_i = r32;
      rdata64_i = r64;
      #1 chk_req(op, a, wd);
      step;
      addr_ok_i = 1'b0;
      data_ok_i = 1'b0;
      for (int j = 1; j <= dd; j++) begin
         if (j == dd) data_ok_i = 1'b1;
         #1;
         chk("req_wait", {req_a, req_b}, 2'b00);
         chk("stall_wait", {stall_a, stall_b}, 2'b11);
         chk("busy_wait", {busy_a, busy_b}, 2'b11);
         step;
         data_ok_i = 1'b0;
      end
      if (ld) begin
         exp_rd32 = exp_ld(4, {32'd0, r32}, a, op);
         exp_rd64 = exp_ld(8, r64, a, op);
      end
      #1;
      chk("stall_done", {stall_a, stall_b}, 2'b00);
      chk("busy_done", {busy_a, busy_b}, 2'b11);
      chk("req_done", {req_a, req_b}, 2'b00);
      chk("rvalid_done", {rvalid_a, rvalid_b}, {ld, ld});
      chk("rdata_a", rdata_a, exp_rd32);
      chk("rdata_b", rdata_b, exp_rd64);
      step;
      valid_i = 1'b0;
      #1;
      chk("busy_idle", {busy_a, busy_b}, 2'b00);
      chk("rvalid_idle", {rvalid_a, rvalid_b}, 2'b00);
      chk("rdata_hold_a", rdata_a, exp_rd32);
   endtask

   task automatic access(input logic [5:0] op, input logic [31:0] a,
      input logic [31:0] wd, input int ad, input int dd,
      input logic [31:0] r32, input logic [63:0] r64);
      int nb;
      bit mis;
      nb  = nbytes(op);
      mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
      valid_i  = 1'b1;
      opcode_i = op;
      addr_i   = a;
      wdata_i  = wd;
      #1;
      if (nb == 0 || mis) begin
         chk("stall_nostart", {stall_a, stall_b}, 2'b00);
         chk("adel", {adel_a, adel_b}, {2{is_ld(op) & mis}});
         chk("ades", {ades_a, ades_b}, {2{is_st(op) & mis}});
         chk("badvaddr_a", bad_a, a);
         chk("badvaddr_b", bad_b, a);
         step;
         chk("req_nostart", {req_a, req_b}, 2'b00);
         chk("busy_nostart", {busy_a, busy_b}, 2'b00);
         valid_i = 1'b0;
         return;
      end
      chk("stall_start", {stall_a, stall_b}, 2'b11);
      chk("exc_start", {adel_a, ades_a, adel_b, ades_b}, 4'b0000);
      step;
      finish_acc(op, a, wd, ad, dd, r32, r64);
   endtask

   initial begin
      logic [5:0] ops [9];
      logic [31:0] r32;
      logic [63:0] r64;
      ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI};
      rst = 1'b1;
      valid_i = 1'b0;
      opcode_i = 6'd0;
      addr_i = 32'd0;
      wdata_i = 32'd0;
      flush_i = 1'b0;
      addr_ok_i = 1'b0;
      data_ok_i = 1'b0;
      rdata32_i = 32'd0;
      rdata64_i = 64'd0;
      exp_rd32 = 32'd0;
      exp_rd64 = 32'd0;
      step;
      step;
      #1;
      chk("rst_req", {req_a, req_b, wr_a, wr_b}, 4'b0000);
      chk("rst_size", {size_a, size_b}, 4'b0000);
      chk("rst_addr", {addr_a, addr_b}, 64'd0);
      chk("rst_wdata_b", wdata_b, 64'd0);
      chk("rst_wdata_a", wdata_a, 64'd0);
      chk("rst_wstrb", {wstrb_a, wstrb_b}, 12'd0);
      chk("rst_rdata", {rdata_a, rdata_b}, 64'd0);
      chk("rst_misc", {rvalid_a, rvalid_b, stall_a, stall_b, busy_a, busy_b},
          6'd0);
      rst = 1'b0;
      step;

      r64 = {32'hDEADBEEF, 32'h80FF1234};
      access(LW, 32'h1000, 0, 0, 0, 32'h80FF1234, r64);
      access(LB, 32'h1003, 0, 0, 0, 32'h80FF1234, r64);
      access(LBU, 32'h1003, 0, 1, 1, 32'h80FF1234, r64);
      access(LHU, 32'h1002, 0, 0, 2, 32'h80FF1234, r64);
      access(SH, 32'h1006, 32'h0000ABCD, 0, 0, 32'd0, 64'd0);
      access(LH, 32'h1006, 0, 0, 0, 32'h80FF1234, 64'h8001_0000_0000_0000);
      access(LW, 32'h1002, 0, 0, 0, 32'd0, 64'd0);
      access(SH, 32'h1001, 32'h1234, 0, 0, 32'd0, 64'd0);

      // flushed LW drains while the next LW waits behind it
      valid_i = 1'b1; opcode_i = LW; addr_i = 32'h2000;
      #1 chk("dr_stall0", stall_a, 1);
      step;
      for (int i = 0; i < 3; i++) begin
         #1 chk_req(LW, 32'h2000, 0);
         step;
      end
      addr_ok_i = 1'b1;
      #1 chk_req(LW, 32'h2000, 0);
      step;
      addr_ok_i = 1'b0;
      flush_i = 1'b1;
      #1 chk("dr_req_wait", {req_a, req_b}, 2'b00);
      step;
      flush_i = 1'b0;
      addr_i = 32'h2004;
      data_ok_i = 1'b1;
      rdata32_i = 32'h5555AAAA;
      rdata64_i = 64'h5555AAAA5555AAAA;
      #1 chk("dr_stall_kill", {stall_a, stall_b}, 2'b11);
      chk("dr_busy", {busy_a, busy_b}, 2'b11);
      step;
      data_ok_i = 1'b0;
      #1 chk("dr_rvalid", {rvalid_a, rvalid_b}, 2'b00);
      chk("dr_stall_done", {stall_a, stall_b}, 2'b11);
      chk("dr_req_done", {req_a, req_b}, 2'b00);
      chk("dr_rdata_hold", rdata_a, exp_rd32);
      step;
      finish_acc(LW, 32'h2004, 0, 0, 1, 32'h0BADF00D,
                 64'h0BADF00D_12345678);

      // reset while waiting for data; a stray data_ok afterwards is ignored
      valid_i = 1'b1; opcode_i = LW; addr_i = 32'h3000;
      step;
      addr_ok_i = 1'b1;
      step;
      addr_ok_i = 1'b0;
      rst = 1'b1;
      #1 chk("rs_busy_wait", {busy_a, busy_b}, 2'b11);
      step;
      rst = 1'b0;
      valid_i = 1'b0;
      exp_rd32 = 32'd0;
      exp_rd64 = 32'd0;
      #1 chk("rs_req", {req_a, req_b}, 2'b00);
      chk("rs_busy", {busy_a, busy_b}, 2'b00);
      chk("rs_rvalid", {rvalid_a, rvalid_b}, 2'b00);
      data_ok_i = 1'b1;
      step;
      data_ok_i = 1'b0;
      #1 chk("rs_dok_ignored", {rvalid_a, rvalid_b, busy_a, busy_b}, 4'd0);
      chk("rs_rdata", {rdata_a, rdata_b}, 64'd0);

      for (int n = 0; n < 60; n++) begin
         r32 = $urandom;
         r64 = {$urandom, $urandom};
         access(ops[$urandom_range(0, 8)], $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                r32, r64);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
